// File: rtl/inst_trace_buffer_if.sv
// Trace output stream: head-of-FIFO commit record with a valid/ready handshake.
interface inst_trace_buffer_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
);
    logic               valid;
    logic               ready;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] inst;
    logic [15:0]        seq;
    logic [31:0]        ts;

    modport master (
        output valid,
        output pc,
        output inst,
        output seq,
        output ts,
        input  ready
    );

    modport slave (
        input  valid,
        input  pc,
        input  inst,
        input  seq,
        input  ts,
        output ready
    );
endinterface

// File: rtl/inst_trace_buffer.sv
// Commit-stream trace buffer: captures (pc, inst) while running, tags with seq, FWFT FIFO out.
// Optional TRACE_TIMESTAMP_EN adds a free-running cycle counter sampled into each entry.
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module inst_trace_buffer #(
    parameter int ADDR_W      = `ADDR_LEN,
    parameter int INSTR_W     = `INSTR_LEN,
    parameter int DEPTH       = 16,
    parameter int HALT_REPEAT = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [ADDR_W-1:0]        i_pc,
    input  logic [INSTR_W-1:0]       i_inst,
    input  logic                     i_start,
    input  logic                     i_clear,
    inst_trace_buffer_if.master      o_trace,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    output logic [15:0]              o_drop_cnt,
    output logic                     o_running,
    output logic                     o_halted
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int RW = $clog2(HALT_REPEAT) + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [ADDR_W-1:0]  r_mem_pc   [DEPTH];
    logic [INSTR_W-1:0] r_mem_inst [DEPTH];
    logic [15:0]        r_mem_seq  [DEPTH];

    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic [15:0]        r_seq;
    logic [RW-1:0]      r_rep_cnt;
    logic               r_have_prev;
    logic [ADDR_W-1:0]  r_prev_pc;
    logic               r_overflow;
    logic [15:0]        r_drop_cnt;
    logic [ADDR_W-1:0]  r_hold_pc;
    logic [INSTR_W-1:0] r_hold_inst;
    logic [15:0]        r_hold_seq;

    logic               w_capture;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic               w_halt_hit;
    logic [RW-1:0]      w_rep_next;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CW'(DEPTH));
    // clear pre-empts every capture and pop on its edge
    assign w_capture  = (r_state == S_RUN) && !i_clear;
    assign w_pop      = !w_empty && o_trace.ready && !i_clear;
    assign w_push     = w_capture && (!w_full || w_pop);
    assign w_drop     = w_capture && w_full && !w_pop;
    assign w_rep_next = (r_have_prev && (i_pc == r_prev_pc)) ? (r_rep_cnt + RW'(1)) : '0;
    assign w_halt_hit = w_capture && (w_rep_next == RW'(HALT_REPEAT - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_state_next = S_RUN;
            S_RUN:    if (w_halt_hit) w_state_next = S_HALTED;
            S_HALTED: w_state_next = S_HALTED;
            default:  w_state_next = S_IDLE;
        endcase
        if (i_clear) begin
            w_state_next = S_IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_seq       <= '0;
            r_rep_cnt   <= '0;
            r_have_prev <= 1'b0;
            r_prev_pc   <= '0;
            r_overflow  <= 1'b0;
            r_drop_cnt  <= '0;
            r_hold_pc   <= '0;
            r_hold_inst <= '0;
            r_hold_seq  <= '0;
        end else if (i_clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_seq       <= '0;
            r_rep_cnt   <= '0;
            r_have_prev <= 1'b0;
            r_prev_pc   <= '0;
            r_overflow  <= 1'b0;
            r_drop_cnt  <= '0;
            r_hold_pc   <= '0;
            r_hold_inst <= '0;
            r_hold_seq  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            // popped head is kept so the outputs hold their last value once empty
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + PW'(1);
                r_hold_pc   <= r_mem_pc[r_rd_ptr];
                r_hold_inst <= r_mem_inst[r_rd_ptr];
                r_hold_seq  <= r_mem_seq[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 16'hFFFF) begin
                    r_drop_cnt <= r_drop_cnt + 16'd1;
                end
            end
            if (w_capture) begin
                r_seq       <= r_seq + 16'd1;
                r_rep_cnt   <= w_rep_next;
                r_have_prev <= 1'b1;
                r_prev_pc   <= i_pc;
            end else if (r_state == S_IDLE) begin
                r_rep_cnt   <= '0;
                r_have_prev <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]   <= i_pc;
            r_mem_inst[r_wr_ptr] <= i_inst;
            r_mem_seq[r_wr_ptr]  <= r_seq;
        end
    end

    assign o_trace.valid = !w_empty;
    assign o_trace.pc    = w_empty ? r_hold_pc   : r_mem_pc[r_rd_ptr];
    assign o_trace.inst  = w_empty ? r_hold_inst : r_mem_inst[r_rd_ptr];
    assign o_trace.seq   = w_empty ? r_hold_seq  : r_mem_seq[r_rd_ptr];

`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] r_ts_cnt;
    logic [31:0] r_hold_ts;
    logic [31:0] r_mem_ts [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ts_cnt  <= '0;
            r_hold_ts <= '0;
        end else if (i_clear) begin
            r_ts_cnt  <= '0;
            r_hold_ts <= '0;
        end else begin
            r_ts_cnt <= r_ts_cnt + 32'd1;
            if (w_pop) begin
                r_hold_ts <= r_mem_ts[r_rd_ptr];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_ts[r_wr_ptr] <= r_ts_cnt;
        end
    end

    assign o_trace.ts = w_empty ? r_hold_ts : r_mem_ts[r_rd_ptr];
`else
    assign o_trace.ts = '0;
`endif

    assign o_count    = r_count;
    assign o_overflow = r_overflow;
    assign o_drop_cnt = r_drop_cnt;
    assign o_running  = (r_state == S_RUN);
    assign o_halted   = (r_state == S_HALTED);

endmodule
